// File: rtl/common_pkg.sv
// Shared definitions for the posit arithmetic cluster.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// NREQ_MAX bounds the requester count of any scheduler sharing an adder.
// posit_t is the default 7-bit posit bit pattern carried between units.
package common;

  localparam int NREQ_MAX = 8;
  localparam int POSIT_W  = 7;

  typedef logic [POSIT_W-1:0] posit_t;

endpackage

// File: rtl/posit_add_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr, wrapping to 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a zero request vector gives a zero grant.
//
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  index the search starts from (must be < N)
//   gnt  out N   one-hot grant, or zero
//   idx  out IW  encoded index of the grant (0 when no grant)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          w_found;
  logic [IW-1:0] w_pos;

  // Visit positions ptr, ptr+1, ... in ascending order with wrap-around;
  // the first requester encountered wins.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = IW'((int'(ptr) + k) % N);
      if (!w_found && req[w_pos]) begin
        w_found    = 1'b1;
        gnt[w_pos] = 1'b1;
        idx        = w_pos;
      end
    end
  end

endmodule

// File: rtl/posit_add_sched.sv
// Round-robin scheduler sharing one combinational posit adder among NREQ requesters.
// Latency: pair accepted at edge t, sum visible in resp_q/resp_valid just after edge t.
// Backpressure: a requester whose response slot is still full is not eligible (no bypass).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester operand handshake (req_ready is the grant)
//   req_a, req_b           packed operand pairs, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/resp_ready  per-requester result handshake
//   resp_q                 packed registered results, same packing as req_a
//   add_a, add_b, add_q    shared adder operands and its same-cycle result
//   op_count               saturating count of issued additions
module posit_add_sched
  import common::*;
#(
  parameter int WIDTH = 7,
  parameter int NREQ  = 4,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [NREQ*WIDTH-1:0] resp_q,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_q,
  output logic [CNTW-1:0]       op_count
);

  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("posit_add_sched: NREQ must be in 2..NREQ_MAX");
  end

  logic [NREQ-1:0]       r_resp_valid;
  logic [NREQ*WIDTH-1:0] r_resp_q;
  logic [PW-1:0]         r_ptr;
  logic [CNTW-1:0]       r_cnt;

  logic [NREQ-1:0]       w_elig;
  logic [NREQ-1:0]       w_gnt;
  logic [PW-1:0]         w_idx;
  logic                  w_any;
  logic [WIDTH-1:0]      w_add_a;
  logic [WIDTH-1:0]      w_add_b;

  // Gating with rst_n keeps req_ready low while reset is held, even though
  // the slots already read empty then.
  assign w_elig = req_valid & ~r_resp_valid & {NREQ{rst_n}};
  assign w_any  = |w_gnt;

  rr_arbiter #(
    .N  (NREQ),
    .IW (PW)
  ) u_arb (
    .req (w_elig),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx)
  );

  // AND-OR operand mux; no grant leaves the adder at 0+0.
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_add_a = req_a[i*WIDTH +: WIDTH];
        w_add_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // A granted slot is empty by construction, so a grant and a drain of the
  // same slot never coincide; drains of other slots proceed independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= '0;
      r_resp_q     <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt[i]) begin
          r_resp_valid[i]            <= 1'b1;
          r_resp_q[i*WIDTH +: WIDTH] <= add_q;
        end else if (r_resp_valid[i] && resp_ready[i]) begin
          r_resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Pointer moves to the requester after the winner; idle cycles hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_any) begin
      if (w_idx == PW'(NREQ - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_any && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign req_ready  = w_gnt;
  assign resp_valid = r_resp_valid;
  assign resp_q     = r_resp_q;
  assign add_a      = w_add_a;
  assign add_b      = w_add_b;
  assign op_count   = r_cnt;

endmodule

// File: tb/tb_posit_add_sched.sv
// Self-checking bench for posit_add_sched (WIDTH=7, NREQ=4).
// A second instance with CNTW=4 shares the stimulus to observe counter saturation.
// The shared adder is modelled as a plain modulo-2^7 sum.
module tb_posit_add_sched;
  import common::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid, resp_ready;
  logic [27:0]   req_a, req_b;
  logic [3:0]    req_ready, resp_valid, req_ready2, resp_valid2;
  logic [27:0]   resp_q, resp_q2;
  logic [6:0]    add_a, add_b, add_q, add_a2, add_b2, add_q2;
  logic [15:0]   op_count;
  logic [3:0]    op_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign add_q  = add_a + add_b;
  assign add_q2 = add_a2 + add_b2;

  posit_add_sched #(.WIDTH(7), .NREQ(4), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_q(resp_q),
    .add_a(add_a), .add_b(add_b), .add_q(add_q),
    .op_count(op_count)
  );

  posit_add_sched #(.WIDTH(7), .NREQ(4), .CNTW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid2), .resp_ready(resp_ready), .resp_q(resp_q2),
    .add_a(add_a2), .add_b(add_b2), .add_q(add_q2),
    .op_count(op_count2)
  );

  typedef struct {
    logic [3:0]  rv;       // req_valid
    logic [3:0]  rr;       // resp_ready
    logic [3:0]  exp_rdy;  // expected req_ready this cycle
    logic [3:0]  exp_vld;  // expected resp_valid this cycle
    logic [15:0] exp_cnt;  // expected op_count this cycle
  } vec_t;

  vec_t   vecs[19];
  posit_t opa[4], opb[4], sum[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected shared-adder operands follow from the expected grant.
  task automatic chk_ops(input string tag, input logic [3:0] rdy);
    posit_t ea, eb;
    ea = '0;
    eb = '0;
    for (int i = 0; i < 4; i++) begin
      if (rdy[i]) begin
        ea = opa[i];
        eb = opb[i];
      end
    end
    chk({tag, " add_a"}, 32'(add_a), 32'(ea));
    chk({tag, " add_b"}, 32'(add_b), 32'(eb));
  endtask

  task automatic chk_slots(input string tag, input logic [3:0] vld);
    for (int i = 0; i < 4; i++) begin
      if (vld[i]) chk($sformatf("%s resp_q[%0d]", tag, i), 32'(resp_q[i*7 +: 7]), 32'(sum[i]));
    end
  endtask

  initial begin
    opa[0] = 7'h10; opb[0] = 7'h08; sum[0] = 7'h18;
    opa[1] = 7'h21; opb[1] = 7'h05; sum[1] = 7'h26;
    opa[2] = 7'h32; opb[2] = 7'h4E; sum[2] = 7'h00;  // 0x80 wraps
    opa[3] = 7'h7F; opb[3] = 7'h03; sum[3] = 7'h02;  // 0x82 wraps

    // Single request, full-slot blocking, pointer wrap, lone requester.
    vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd0};
    vecs[1]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 16'd0};
    vecs[2]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 16'd1};
    vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd1};
    vecs[4]  = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 16'd1};
    vecs[5]  = '{4'b0111, 4'b0000, 4'b0001, 4'b0100, 16'd2};
    vecs[6]  = '{4'b0110, 4'b0000, 4'b0010, 4'b0101, 16'd3};
    vecs[7]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0111, 16'd4};
    vecs[8]  = '{4'b0100, 4'b0000, 4'b0100, 4'b0011, 16'd4};
    vecs[9]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0111, 16'd5};
    vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd5};
    vecs[11] = '{4'b1001, 4'b1111, 4'b1000, 4'b0000, 16'd5};
    vecs[12] = '{4'b0001, 4'b1111, 4'b0001, 4'b1000, 16'd6};
    vecs[13] = '{4'b0000, 4'b1111, 4'b0000, 4'b0001, 16'd7};
    vecs[14] = '{4'b0010, 4'b1111, 4'b0010, 4'b0000, 16'd7};
    vecs[15] = '{4'b0000, 4'b1111, 4'b0000, 4'b0010, 16'd8};
    vecs[16] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 16'd8};
    vecs[17] = '{4'b0000, 4'b1111, 4'b0000, 4'b0010, 16'd9};
    vecs[18] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd9};

    for (int i = 0; i < 4; i++) begin
      req_a[i*7 +: 7] = opa[i];
      req_b[i*7 +: 7] = opb[i];
    end
    rst_n      = 1'b0;
    req_valid  = 4'b1111;  // presented during reset: must not be accepted
    resp_ready = 4'b0000;

    repeat (2) @(negedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'h0);
    chk("reset resp_valid", 32'(resp_valid), 32'h0);
    chk("reset resp_q", 32'(resp_q), 32'h0);
    chk("reset op_count", 32'(op_count), 32'h0);
    chk_ops("reset", 4'b0000);

    @(negedge clk);
    req_valid = 4'b0000;
    rst_n = 1'b1;

    for (int r = 0; r < 19; r++) begin
      @(negedge clk);
      req_valid  = vecs[r].rv;
      resp_ready = vecs[r].rr;
      #1;
      chk($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(vecs[r].exp_rdy));
      chk($sformatf("row%0d resp_valid", r), 32'(resp_valid), 32'(vecs[r].exp_vld));
      chk($sformatf("row%0d op_count", r), 32'(op_count), 32'(vecs[r].exp_cnt));
      chk_ops($sformatf("row%0d", r), vecs[r].exp_rdy);
      chk_slots($sformatf("row%0d", r), vecs[r].exp_vld);
    end

    // Fill slots 3 and 1 (pointer is 2), then reset mid-operation.
    @(negedge clk);
    req_valid = 4'b1010; resp_ready = 4'b0000;
    #1 chk("mid grant3", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = 4'b0010;
    #1 chk("mid grant1", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("mid slots", 32'(resp_valid), 32'b1010);
    chk("mid grant2", 32'(req_ready), 32'b0100);
    chk("mid op_count", 32'(op_count), 32'd11);
    rst_n = 1'b0;
    #1;
    chk("arst resp_valid", 32'(resp_valid), 32'h0);
    chk("arst req_ready", 32'(req_ready), 32'h0);
    chk("arst op_count", 32'(op_count), 32'h0);
    chk("arst op_count sat", 32'(op_count2), 32'h0);
    chk("arst resp_q", 32'(resp_q), 32'h0);
    chk_ops("arst", 4'b0000);
    @(negedge clk);  // a rising edge has passed under reset
    #1;
    chk("held req_ready", 32'(req_ready), 32'h0);
    chk("held op_count", 32'(op_count), 32'h0);

    // Full contention from release: grants rotate 0,1,2,3,... one per cycle.
    rst_n = 1'b1;
    resp_ready = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("cont%0d req_ready", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      chk($sformatf("cont%0d op_count", k), 32'(op_count), 32'(k));
      chk($sformatf("cont%0d op_count sat", k), 32'(op_count2), 32'((k > 15) ? 15 : k));
      chk_ops($sformatf("cont%0d", k), 4'b0001 << (k % 4));
      if (k > 0) begin
        chk($sformatf("cont%0d resp_valid", k), 32'(resp_valid), 32'(4'b0001 << ((k - 1) % 4)));
        chk_slots($sformatf("cont%0d", k), 4'b0001 << ((k - 1) % 4));
      end
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("final op_count", 32'(op_count), 32'd20);
    chk("final op_count sat", 32'(op_count2), 32'hF);
    chk("final sat resp_valid", 32'(resp_valid2), 32'b1000);
    chk("final sat resp_q[3]", 32'(resp_q2[21 +: 7]), 32'(sum[3]));
    chk("final idle req_ready", 32'(req_ready), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
